// File: rtl/sseg_banner_scheduler_pkg.sv
// sseg_banner_scheduler_pkg: scan state encoding and index-width helper
package sseg_banner_scheduler_pkg;
  typedef enum logic {ST_GUARD = 1'b0, ST_SCAN = 1'b1} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sseg_tick_div.sv
// sseg_tick_div: enable-gated cycle divider, tick high on the last enabled cycle of each DIV-cycle period
// ports: clk, reset (sync, active-high), en (count enable), clr (restart from 0), tick (terminal count, combinational)
module sseg_tick_div import sseg_banner_scheduler_pkg::*; #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = idx_w(DIV);
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(DIV - 1);
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/sseg_banner_scheduler.sv
// sseg_banner_scheduler: multiplexed 7-seg scanner rotating a loadable hex banner on frame boundaries
// ports: clk, reset (sync, active-high); load_valid/load_data/load_ready banner load handshake;
//        run/dir/blank rotation and display control; anodes (active low, msb = leftmost), digit,
//        rot_ptr, frame_start (pulse when position 0 lights)
module sseg_banner_scheduler import sseg_banner_scheduler_pkg::*; #(
  parameter int N_DIGITS   = 4,
  parameter int BANNER_LEN = 16,
  parameter int SCAN_DIV   = 100_000,
  parameter int GUARD_DIV  = 1_000,
  parameter int ROT_DIV    = 25_000_000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load_valid,
  input  logic [4*BANNER_LEN-1:0]         load_data,
  output logic                            load_ready,
  input  logic                            run,
  input  logic                            dir,
  input  logic                            blank,
  output logic [N_DIGITS-1:0]             anodes,
  output logic [3:0]                      digit,
  output logic [idx_w(BANNER_LEN)-1:0]    rot_ptr,
  output logic                            frame_start
);
  localparam int PW = idx_w(BANNER_LEN);
  localparam int QW = idx_w(N_DIGITS);
  state_t state, state_n;
  logic [QW-1:0] pos, pos_n;
  logic [BANNER_LEN-1:0][3:0] banner;
  logic [PW-1:0] rot_n;
  logic [PW:0] sum, idx;
  logic step_pending, g_tick, s_tick, r_tick, ld, start, apply, scan_end;
  assign ld = load_valid & load_ready;
  assign scan_end = state == ST_SCAN && s_tick;
  // guard and scan phases have their own terminal counts, so each gets a divider
  sseg_tick_div #(.DIV(GUARD_DIV)) u_guard (.clk(clk), .reset(reset), .en(state == ST_GUARD), .clr(ld), .tick(g_tick));
  sseg_tick_div #(.DIV(SCAN_DIV)) u_scan (.clk(clk), .reset(reset), .en(state == ST_SCAN), .clr(ld), .tick(s_tick));
  sseg_tick_div #(.DIV(ROT_DIV)) u_rot (.clk(clk), .reset(reset), .en(run), .clr(ld | ~run), .tick(r_tick));
  always_comb begin
    start = state == ST_GUARD && g_tick;
    apply = start && pos == '0 && step_pending;
    rot_n = !apply ? rot_ptr
          : dir ? (rot_ptr == '0 ? PW'(BANNER_LEN - 1) : rot_ptr - PW'(1))
          : (rot_ptr == PW'(BANNER_LEN - 1) ? '0 : rot_ptr + PW'(1));
    state_n = ld ? ST_GUARD : start ? ST_SCAN : scan_end ? ST_GUARD : state;
    pos_n = ld ? '0 : !scan_end ? pos : pos == QW'(N_DIGITS - 1) ? '0 : pos + QW'(1);
    // rot_n and pos are both below BANNER_LEN, so one conditional subtract wraps the sum
    sum = (PW+1)'(rot_n) + (PW+1)'(pos);
    idx = sum >= (PW+1)'(BANNER_LEN) ? sum - (PW+1)'(BANNER_LEN) : sum;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= ST_GUARD;
      pos <= '0;
      banner <= '0;
      rot_ptr <= '0;
      step_pending <= 1'b0;
      anodes <= '1;
      digit <= '0;
      frame_start <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      state <= state_n;
      pos <= pos_n;
      load_ready <= 1'b1;
      rot_ptr <= ld ? '0 : rot_n;
      step_pending <= ld ? 1'b0 : r_tick ? 1'b1 : apply ? 1'b0 : step_pending;
      anodes <= state_n == ST_SCAN && !blank ? ~(N_DIGITS'(1) << (QW'(N_DIGITS - 1) - pos_n)) : '1;
      frame_start <= start && !ld && pos == '0;
      if (ld) banner <= load_data;
      if (start && !ld) digit <= banner[idx[PW-1:0]];
    end
endmodule
